// File: rtl/ray_config_bank.sv
// Control/status register slave for a bank of ray-tracing cores: holds the shared scene and
// camera configuration, broadcasts per-core control pulses, and aggregates completion interrupts.
module ray_config_bank #(
    parameter int CORES          = 4,
    parameter int POSITION_WIDTH = 16,
    parameter int DATA_WIDTH     = 24,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int ID_WIDTH       = 4,
    parameter int ADDRESS        = 0,
    parameter int BASE_WIDTH     = 5,
    parameter int ADDR_SHIFT     = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [ADDRESS_WIDTH-1:0]    msAddress,
    input  logic                        msValid,
    input  logic                        msWrite,
    input  logic [DATA_WIDTH-1:0]       msData,
    input  logic [ID_WIDTH-1:0]         msID,
    output logic                        msTaken,
    output logic                        smValid,
    input  logic                        smTaken,
    output logic [DATA_WIDTH-1:0]       smData,
    output logic [ID_WIDTH-1:0]         smID,
    output logic [ADDRESS_WIDTH-1:0]    materialAddress,
    output logic [ADDRESS_WIDTH-1:0]    treeAddress,
    output logic [ADDRESS_WIDTH-1:0]    frameAddress,
    output logic [3*POSITION_WIDTH-1:0] cameraQ,
    output logic [3*POSITION_WIDTH-1:0] cameraV,
    output logic [3*POSITION_WIDTH-1:0] cameraX,
    output logic [3*POSITION_WIDTH-1:0] cameraY,
    output logic [11:0]                 width,
    output logic [11:0]                 height,
    output logic                        normalize,
    output logic [CORES-1:0]            start,
    output logic [CORES-1:0]            flush,
    output logic [CORES-1:0]            resetRT,
    input  logic [CORES-1:0]            ready,
    input  logic [CORES-1:0]            busy,
    output logic                        interrupt
);

    localparam logic [BASE_WIDTH-1:0] OFF_CONTROL    = BASE_WIDTH'(0);
    localparam logic [BASE_WIDTH-1:0] OFF_ENABLE     = BASE_WIDTH'(1);
    localparam logic [BASE_WIDTH-1:0] OFF_IRQ_STATUS = BASE_WIDTH'(2);
    localparam logic [BASE_WIDTH-1:0] OFF_IRQ_MASK   = BASE_WIDTH'(3);
    localparam logic [BASE_WIDTH-1:0] OFF_STATUS     = BASE_WIDTH'(4);
    localparam logic [BASE_WIDTH-1:0] OFF_MATERIAL   = BASE_WIDTH'(5);
    localparam logic [BASE_WIDTH-1:0] OFF_TREE       = BASE_WIDTH'(6);
    localparam logic [BASE_WIDTH-1:0] OFF_FRAME      = BASE_WIDTH'(7);
    localparam logic [BASE_WIDTH-1:0] OFF_CAM_FIRST  = BASE_WIDTH'(8);
    localparam logic [BASE_WIDTH-1:0] OFF_CAM_LAST   = BASE_WIDTH'(19);
    localparam logic [BASE_WIDTH-1:0] OFF_WIDTH      = BASE_WIDTH'(20);
    localparam logic [BASE_WIDTH-1:0] OFF_HEIGHT     = BASE_WIDTH'(21);

    logic [CORES-1:0]          enable_q, enable_d;
    logic [CORES-1:0]          irq_status_q, irq_status_d;
    logic [CORES-1:0]          irq_mask_q, irq_mask_d;
    logic [CORES-1:0]          ready_prev_q;
    logic                      normalize_q, normalize_d;
    logic [DATA_WIDTH-1:0]     material_q, material_d;
    logic [DATA_WIDTH-1:0]     tree_q, tree_d;
    logic [DATA_WIDTH-1:0]     frame_q, frame_d;
    logic [POSITION_WIDTH-1:0] cam_q [12];
    logic [POSITION_WIDTH-1:0] cam_d [12];
    logic [11:0]               width_q, width_d;
    logic [11:0]               height_q, height_d;
    logic                      sm_valid_q, sm_valid_d;
    logic [DATA_WIDTH-1:0]     sm_data_q, sm_data_d;
    logic [ID_WIDTH-1:0]       sm_id_q, sm_id_d;
    logic                      interrupt_q, interrupt_d;

    logic                      select;
    logic                      accept;
    logic                      wr;
    logic                      ctrl_wr;
    logic [BASE_WIDTH-1:0]     offset;
    logic                      cam_hit;
    logic [3:0]                cam_idx;
    logic [CORES-1:0]          irq_clr;
    logic [DATA_WIDTH-1:0]     rdata;

    assign offset  = msAddress[BASE_WIDTH-1:0];
    assign select  = (msAddress[ADDRESS_WIDTH-1:BASE_WIDTH] == (ADDRESS_WIDTH-BASE_WIDTH)'(ADDRESS));
    // The response slot frees up in the same cycle it is consumed, so reads can stream.
    assign msTaken = select && msValid && (!sm_valid_q || smTaken);
    assign accept  = msTaken;
    assign wr      = accept && msWrite;
    assign ctrl_wr = wr && (offset == OFF_CONTROL);
    assign cam_hit = (offset >= OFF_CAM_FIRST) && (offset <= OFF_CAM_LAST);
    assign cam_idx = 4'(offset - OFF_CAM_FIRST);
    assign irq_clr = (wr && (offset == OFF_IRQ_STATUS)) ? msData[CORES-1:0] : '0;

    always_comb begin
        rdata = '0;
        case (offset)
            OFF_CONTROL: begin
                rdata[5] = normalize_q;
                rdata[2] = |busy;
                rdata[1] = &(ready | ~enable_q);
            end
            OFF_ENABLE:     rdata[CORES-1:0]   = enable_q;
            OFF_IRQ_STATUS: rdata[CORES-1:0]   = irq_status_q;
            OFF_IRQ_MASK:   rdata[CORES-1:0]   = irq_mask_q;
            OFF_STATUS:     rdata[2*CORES-1:0] = {busy, ready};
            OFF_MATERIAL:   rdata = material_q;
            OFF_TREE:       rdata = tree_q;
            OFF_FRAME:      rdata = frame_q;
            OFF_WIDTH:      rdata[11:0] = width_q;
            OFF_HEIGHT:     rdata[11:0] = height_q;
            default: begin
                if (cam_hit) rdata[POSITION_WIDTH-1:0] = cam_q[cam_idx];
            end
        endcase
    end

    always_comb begin
        enable_d    = enable_q;
        irq_mask_d  = irq_mask_q;
        normalize_d = normalize_q;
        material_d  = material_q;
        tree_d      = tree_q;
        frame_d     = frame_q;
        cam_d       = cam_q;
        width_d     = width_q;
        height_d    = height_q;
        if (wr) begin
            case (offset)
                OFF_CONTROL:  normalize_d = msData[5];
                OFF_ENABLE:   enable_d    = msData[CORES-1:0];
                OFF_IRQ_MASK: irq_mask_d  = msData[CORES-1:0];
                OFF_MATERIAL: material_d  = msData;
                OFF_TREE:     tree_d      = msData;
                OFF_FRAME:    frame_d     = msData;
                OFF_WIDTH:    width_d     = msData[11:0];
                OFF_HEIGHT:   height_d    = msData[11:0];
                default: begin
                    if (cam_hit) cam_d[cam_idx] = msData[POSITION_WIDTH-1:0];
                end
            endcase
        end
        // A fresh ready edge overrides a coincident write-1-to-clear.
        irq_status_d = (irq_status_q & ~irq_clr) | (ready & ~ready_prev_q);
        interrupt_d  = |(irq_status_q & irq_mask_q);

        sm_valid_d = sm_valid_q;
        sm_data_d  = sm_data_q;
        sm_id_d    = sm_id_q;
        if (accept && !msWrite) begin
            sm_valid_d = 1'b1;
            sm_data_d  = rdata;
            sm_id_d    = msID;
        end else if (smTaken) begin
            sm_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            enable_q     <= '0;
            irq_status_q <= '0;
            irq_mask_q   <= '0;
            ready_prev_q <= ready;
            normalize_q  <= 1'b0;
            material_q   <= '0;
            tree_q       <= '0;
            frame_q      <= '0;
            for (int i = 0; i < 12; i++) cam_q[i] <= '0;
            width_q      <= '0;
            height_q     <= '0;
            sm_valid_q   <= 1'b0;
            sm_data_q    <= '0;
            sm_id_q      <= '0;
            interrupt_q  <= 1'b0;
        end else begin
            enable_q     <= enable_d;
            irq_status_q <= irq_status_d;
            irq_mask_q   <= irq_mask_d;
            ready_prev_q <= ready;
            normalize_q  <= normalize_d;
            material_q   <= material_d;
            tree_q       <= tree_d;
            frame_q      <= frame_d;
            cam_q        <= cam_d;
            width_q      <= width_d;
            height_q     <= height_d;
            sm_valid_q   <= sm_valid_d;
            sm_data_q    <= sm_data_d;
            sm_id_q      <= sm_id_d;
            interrupt_q  <= interrupt_d;
        end
    end

    assign start   = (ctrl_wr && msData[0] && !reset) ? enable_q : '0;
    assign flush   = (ctrl_wr && msData[3] && !reset) ? enable_q : '0;
    assign resetRT = reset ? '1 : ((ctrl_wr && msData[4]) ? enable_q : '0);

    assign materialAddress = ADDRESS_WIDTH'(material_q) << ADDR_SHIFT;
    assign treeAddress     = ADDRESS_WIDTH'(tree_q) << ADDR_SHIFT;
    assign frameAddress    = ADDRESS_WIDTH'(frame_q) << ADDR_SHIFT;
    assign cameraQ   = {cam_q[2],  cam_q[1],  cam_q[0]};
    assign cameraV   = {cam_q[5],  cam_q[4],  cam_q[3]};
    assign cameraX   = {cam_q[8],  cam_q[7],  cam_q[6]};
    assign cameraY   = {cam_q[11], cam_q[10], cam_q[9]};
    assign width     = width_q;
    assign height    = height_q;
    assign normalize = normalize_q;
    assign smValid   = sm_valid_q;
    assign smData    = sm_data_q;
    assign smID      = sm_id_q;
    assign interrupt = interrupt_q;

endmodule

// File: tb/tb_ray_config_bank.sv
// Directed bench for ray_config_bank: register access, control pulses, read flow control,
// interrupt set/clear ordering and unmapped/out-of-block accesses.
module tb_ray_config_bank;

    logic        clk;
    logic        reset;
    logic [31:0] msAddress;
    logic        msValid;
    logic        msWrite;
    logic [23:0] msData;
    logic [3:0]  msID;
    logic        msTaken;
    logic        smValid;
    logic        smTaken;
    logic [23:0] smData;
    logic [3:0]  smID;
    logic [31:0] materialAddress, treeAddress, frameAddress;
    logic [47:0] cameraQ, cameraV, cameraX, cameraY;
    logic [11:0] width, height;
    logic        normalize;
    logic [3:0]  start, flush, resetRT;
    logic [3:0]  ready, busy;
    logic        interrupt;

    int checks;
    int errors;

    ray_config_bank dut (
        .clock(clk), .reset(reset),
        .msAddress(msAddress), .msValid(msValid), .msWrite(msWrite), .msData(msData), .msID(msID),
        .msTaken(msTaken), .smValid(smValid), .smTaken(smTaken), .smData(smData), .smID(smID),
        .materialAddress(materialAddress), .treeAddress(treeAddress), .frameAddress(frameAddress),
        .cameraQ(cameraQ), .cameraV(cameraV), .cameraX(cameraX), .cameraY(cameraY),
        .width(width), .height(height), .normalize(normalize),
        .start(start), .flush(flush), .resetRT(resetRT),
        .ready(ready), .busy(busy), .interrupt(interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_write(input logic [31:0] addr, input logic [23:0] data);
        int n;
        @(negedge clk);
        msAddress = addr; msWrite = 1'b1; msData = data; msValid = 1'b1;
        #1;
        n = 0;
        while (!msTaken && n < 20) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (msTaken !== 1'b1) begin
            errors++;
            $display("FAIL write_accept addr=%h got msTaken=%b want 1", addr, msTaken);
        end
        @(posedge clk); #1;
        msValid = 1'b0; msWrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [3:0] id,
                            output logic [23:0] data, output logic [3:0] rid);
        int n;
        @(negedge clk);
        msAddress = addr; msWrite = 1'b0; msID = id; msValid = 1'b1; smTaken = 1'b0;
        #1;
        n = 0;
        while (!msTaken && n < 20) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (msTaken !== 1'b1) begin
            errors++;
            $display("FAIL read_accept addr=%h got msTaken=%b want 1", addr, msTaken);
        end
        @(posedge clk); #1;
        msValid = 1'b0;
        n = 0;
        while (!smValid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (smValid !== 1'b1) begin
            errors++;
            $display("FAIL read_response addr=%h got smValid=%b want 1", addr, smValid);
        end
        data = smData; rid = smID;
        smTaken = 1'b1;
        @(posedge clk); #1;
        smTaken = 1'b0;
    endtask

    task automatic test_reset;
        logic [23:0] d;
        logic [3:0]  id;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (resetRT !== 4'hF) begin errors++; $display("FAIL reset_resetRT got=%h want=f", resetRT); end
        checks++;
        if (start !== 4'h0 || flush !== 4'h0) begin
            errors++; $display("FAIL reset_pulses got start=%h flush=%h want 0 0", start, flush);
        end
        checks++;
        if (materialAddress !== 32'h0 || cameraQ !== 48'h0 || width !== 12'h0 || normalize !== 1'b0) begin
            errors++; $display("FAIL reset_regs got mat=%h camQ=%h w=%h norm=%b want 0", materialAddress, cameraQ, width, normalize);
        end
        checks++;
        if (smValid !== 1'b0 || interrupt !== 1'b0) begin
            errors++; $display("FAIL reset_flags got smValid=%b irq=%b want 0 0", smValid, interrupt);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (resetRT !== 4'h0) begin errors++; $display("FAIL post_reset_resetRT got=%h want=0", resetRT); end
        // With no core enabled, "all enabled cores ready" holds vacuously, so bit1 reads as 1.
        bus_read(32'h0, 4'h5, d, id);
        checks++;
        if (d !== 24'h000002) begin errors++; $display("FAIL reset_ctrl_read got=%h want=000002", d); end
        checks++;
        if (id !== 4'h5) begin errors++; $display("FAIL reset_ctrl_id got=%h want=5", id); end
    endtask

    task automatic test_control;
        logic [23:0] d;
        logic [3:0]  id;
        bus_write(32'h1, 24'h000005);
        @(negedge clk);
        msAddress = 32'h0; msWrite = 1'b1; msData = 24'h000021; msValid = 1'b1;
        #1;
        checks++;
        if (msTaken !== 1'b1 || start !== 4'b0101) begin
            errors++; $display("FAIL ctrl_start got taken=%b start=%b want 1 0101", msTaken, start);
        end
        checks++;
        if (flush !== 4'b0000 || resetRT !== 4'b0000) begin
            errors++; $display("FAIL ctrl_other_pulses got flush=%b resetRT=%b want 0000 0000", flush, resetRT);
        end
        @(posedge clk); #1;
        msValid = 1'b0; msWrite = 1'b0;
        #1;
        checks++;
        if (start !== 4'b0000) begin errors++; $display("FAIL ctrl_start_one_cycle got=%b want=0000", start); end
        checks++;
        if (normalize !== 1'b1) begin errors++; $display("FAIL ctrl_normalize got=%b want=1", normalize); end
        bus_read(32'h0, 4'h1, d, id);
        checks++;
        if (d !== 24'h000020) begin errors++; $display("FAIL ctrl_read_idle got=%h want=000020", d); end
        ready = 4'b0101; busy = 4'b0010;
        bus_read(32'h0, 4'h2, d, id);
        checks++;
        if (d !== 24'h000026) begin errors++; $display("FAIL ctrl_read_status got=%h want=000026", d); end
        bus_read(32'h4, 4'h3, d, id);
        checks++;
        if (d !== 24'h000025) begin errors++; $display("FAIL status_read got=%h want=000025", d); end
        @(negedge clk);
        msAddress = 32'h0; msWrite = 1'b1; msData = 24'h000018; msValid = 1'b1;
        #1;
        checks++;
        if (flush !== 4'b0101 || resetRT !== 4'b0101 || start !== 4'b0000) begin
            errors++; $display("FAIL ctrl_flush got flush=%b resetRT=%b start=%b want 0101 0101 0000", flush, resetRT, start);
        end
        @(posedge clk); #1;
        msValid = 1'b0; msWrite = 1'b0;
        #1;
        checks++;
        if (normalize !== 1'b0 || flush !== 4'b0000) begin
            errors++; $display("FAIL ctrl_flush_after got norm=%b flush=%b want 0 0000", normalize, flush);
        end
        ready = 4'b0000; busy = 4'b0000;
    endtask

    task automatic test_base;
        logic [23:0] d;
        logic [3:0]  id;
        bus_write(32'h5, 24'h001234);
        bus_write(32'h7, 24'hABCDEF);
        bus_write(32'h8, 24'hFF1111);
        bus_write(32'h9, 24'h002222);
        bus_write(32'hA, 24'h003333);
        bus_write(32'h14, 24'hFFF123);
        bus_write(32'h13, 24'h00BEEF);
        #1;
        checks++;
        if (materialAddress !== 32'h00123400) begin errors++; $display("FAIL material_addr got=%h want=00123400", materialAddress); end
        checks++;
        if (frameAddress !== 32'hABCDEF00 || treeAddress !== 32'h0) begin
            errors++; $display("FAIL frame_tree_addr got frame=%h tree=%h want abcdef00 0", frameAddress, treeAddress);
        end
        checks++;
        if (cameraQ !== 48'h333322221111) begin errors++; $display("FAIL cameraQ got=%h want=333322221111", cameraQ); end
        checks++;
        if (cameraY !== 48'hBEEF00000000 || cameraV !== 48'h0) begin
            errors++; $display("FAIL cameraY_V got Y=%h V=%h want beef00000000 0", cameraY, cameraV);
        end
        checks++;
        if (width !== 12'h123 || height !== 12'h0) begin errors++; $display("FAIL size got w=%h h=%h want 123 0", width, height); end
        bus_read(32'h5, 4'h6, d, id);
        checks++;
        if (d !== 24'h001234) begin errors++; $display("FAIL material_read got=%h want=001234", d); end
        bus_read(32'h14, 4'h7, d, id);
        checks++;
        if (d !== 24'h000123) begin errors++; $display("FAIL width_read got=%h want=000123", d); end
        bus_read(32'h8, 4'h8, d, id);
        checks++;
        if (d !== 24'h001111 || id !== 4'h8) begin errors++; $display("FAIL camq_x_read got d=%h id=%h want 001111 8", d, id); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        msAddress = 32'h5; msWrite = 1'b0; msID = 4'h3; msValid = 1'b1; smTaken = 1'b0;
        #1;
        checks++;
        if (msTaken !== 1'b1) begin errors++; $display("FAIL b2b_first_accept got=%b want=1", msTaken); end
        @(negedge clk);
        msAddress = 32'h7; msID = 4'h9;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (smValid !== 1'b1 || smData !== 24'h001234 || smID !== 4'h3) begin
                errors++; $display("FAIL b2b_hold cycle=%0d got v=%b d=%h id=%h want 1 001234 3", i, smValid, smData, smID);
            end
            checks++;
            if (msTaken !== 1'b0) begin errors++; $display("FAIL b2b_stall cycle=%0d got msTaken=%b want 0", i, msTaken); end
            @(negedge clk);
        end
        smTaken = 1'b1;
        #1;
        checks++;
        if (msTaken !== 1'b1) begin errors++; $display("FAIL b2b_same_cycle_accept got=%b want=1", msTaken); end
        @(negedge clk);
        msValid = 1'b0; smTaken = 1'b0;
        #1;
        checks++;
        if (smValid !== 1'b1 || smData !== 24'hABCDEF || smID !== 4'h9) begin
            errors++; $display("FAIL b2b_second got v=%b d=%h id=%h want 1 abcdef 9", smValid, smData, smID);
        end
        smTaken = 1'b1;
        @(negedge clk);
        smTaken = 1'b0;
        #1;
        checks++;
        if (smValid !== 1'b0) begin errors++; $display("FAIL b2b_drain got smValid=%b want 0", smValid); end
    endtask

    task automatic test_irq;
        logic [23:0] d;
        logic [3:0]  id;
        bus_write(32'h2, 24'h00000F);
        bus_write(32'h3, 24'h000003);
        @(negedge clk);
        ready = 4'b0010;
        @(negedge clk); #1;
        checks++;
        if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_latency got=%b want=0", interrupt); end
        @(negedge clk); #1;
        checks++;
        if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_raise got=%b want=1", interrupt); end
        bus_read(32'h2, 4'hA, d, id);
        checks++;
        if (d !== 24'h000002) begin errors++; $display("FAIL irq_status_set got=%h want=000002", d); end
        bus_write(32'h2, 24'h000002);
        @(posedge clk); #1;
        checks++;
        if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b want=0", interrupt); end
        bus_read(32'h2, 4'hB, d, id);
        checks++;
        if (d !== 24'h000000) begin errors++; $display("FAIL irq_status_cleared got=%h want=000000", d); end
        @(negedge clk);
        ready = 4'b0000;
        @(negedge clk);
        ready = 4'b0010;
        msAddress = 32'h2; msWrite = 1'b1; msData = 24'h000002; msValid = 1'b1;
        @(posedge clk); #1;
        msValid = 1'b0; msWrite = 1'b0;
        bus_read(32'h2, 4'hC, d, id);
        checks++;
        if (d !== 24'h000002) begin errors++; $display("FAIL irq_set_wins got=%h want=000002", d); end
        bus_write(32'h2, 24'h00000F);
        @(negedge clk);
        ready = 4'b0110;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_masked got=%b want=0", interrupt); end
        bus_read(32'h2, 4'hD, d, id);
        checks++;
        if (d !== 24'h000004) begin errors++; $display("FAIL irq_masked_status got=%h want=000004", d); end
        ready = 4'b0000;
    endtask

    task automatic test_unmapped;
        logic [23:0] d;
        logic [3:0]  id;
        bus_read(32'h1F, 4'hE, d, id);
        checks++;
        if (d !== 24'h000000 || id !== 4'hE) begin errors++; $display("FAIL unmapped_read got d=%h id=%h want 000000 e", d, id); end
        bus_write(32'h1F, 24'hFFFFFF);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (smValid !== 1'b0) begin errors++; $display("FAIL unmapped_write_resp cycle=%0d got smValid=%b want 0", i, smValid); end
            @(negedge clk);
        end
        checks++;
        if (materialAddress !== 32'h00123400 || width !== 12'h123 || normalize !== 1'b0 || cameraX !== 48'h0) begin
            errors++; $display("FAIL unmapped_write_regs got mat=%h w=%h norm=%b camX=%h want 00123400 123 0 0", materialAddress, width, normalize, cameraX);
        end
        msAddress = 32'h25; msWrite = 1'b1; msData = 24'h00FFFF; msValid = 1'b1;
        #1;
        checks++;
        if (msTaken !== 1'b0) begin errors++; $display("FAIL other_block_taken got=%b want=0", msTaken); end
        @(negedge clk);
        msValid = 1'b0; msWrite = 1'b0;
        #1;
        checks++;
        if (materialAddress !== 32'h00123400) begin errors++; $display("FAIL other_block_write got=%h want=00123400", materialAddress); end
    endtask

    task automatic test_reset_drop;
        @(negedge clk);
        msAddress = 32'h5; msWrite = 1'b0; msID = 4'h4; msValid = 1'b1; smTaken = 1'b0;
        @(negedge clk);
        msValid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (smValid !== 1'b0 || smData !== 24'h0 || smID !== 4'h0) begin
            errors++; $display("FAIL reset_drop got v=%b d=%h id=%h want 0 0 0", smValid, smData, smID);
        end
        checks++;
        if (materialAddress !== 32'h0 || width !== 12'h0) begin
            errors++; $display("FAIL reset_clears got mat=%h w=%h want 0 0", materialAddress, width);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; msAddress = '0; msValid = 1'b0; msWrite = 1'b0; msData = '0; msID = '0;
        smTaken = 1'b0; ready = '0; busy = '0;
        test_reset();
        test_control();
        test_base();
        test_back_to_back();
        test_irq();
        test_unmapped();
        test_reset_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
